// File: rtl/conv1d_pkg.sv
// rtl/conv1d_pkg.sv - sizes, state enums and saturation helper shared by the conv1d engine
// Contents:
//   N, M, T, P, FRAC  vector length, filter length, data width, lanes, product shift
//   L, NG             output length (N-M+1) and number of lane groups per vector
//   *_AW              counter / address widths
//   top_state_t       filter load vs. run
//   comp_state_t      compute sequencer states
//   saturate()        clamp a wide signed value into t-bit two's complement range
package conv1d_pkg;
    localparam int N    = 96;
    localparam int M    = 65;
    localparam int T    = 16;
    localparam int P    = 16;
    localparam int FRAC = 0;

    localparam int L    = N - M + 1;
    localparam int NG   = (L + P - 1) / P;

    localparam int X_AW = $clog2(N);
    localparam int F_AW = $clog2(M + 1);
    // wide enough for base + lane + read index, which can run past N during the pipeline tail
    localparam int A_AW = $clog2(N + M + P + 1);
    localparam int J_AW = $clog2(P + 1);
    localparam int G_AW = $clog2(NG + 1);

    typedef enum logic {
        TOP_LOAD_F,
        TOP_RUN
    } top_state_t;

    typedef enum logic [2:0] {
        C_IDLE,
        C_CLR,
        C_PIPE1,
        C_PIPE2,
        C_MAC,
        C_OUT
    } comp_state_t;

    function automatic logic signed [63:0] saturate(input logic signed [63:0] value, input int t);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (t - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (t - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction
endpackage

// File: rtl/conv1d_lane.sv
// rtl/conv1d_lane.sv - one MAC lane: registered saturated product plus saturating accumulator
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   load_bias    acc <= bias (start of a lane group)
//   enable       acc <= sat(acc + product register)
//   x, f         operands; product is registered every cycle
//   bias         filter bias
//   acc          accumulator value
module conv1d_lane
    import conv1d_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load_bias,
    input  logic                enable,
    input  logic signed [T-1:0] x,
    input  logic signed [T-1:0] f,
    input  logic signed [T-1:0] bias,
    output logic signed [T-1:0] acc
);
    logic signed [2*T-1:0] prod_full;
    logic signed [63:0]    prod_ext;
    logic signed [63:0]    prod_shift;
    logic signed [63:0]    sum_ext;
    logic signed [T-1:0]   prod_q;

    always_comb begin
        prod_full  = (2*T)'(x) * (2*T)'(f);
        prod_ext   = {{(64-2*T){prod_full[2*T-1]}}, prod_full};
        prod_shift = prod_ext >>> FRAC;
        sum_ext    = {{(64-T){acc[T-1]}}, acc} + {{(64-T){prod_q[T-1]}}, prod_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            acc    <= '0;
        end else begin
            prod_q <= T'(saturate(prod_shift, T));
            if (load_bias) begin
                acc <= bias;
            end else if (enable) begin
                acc <= T'(saturate(sum_ext, T));
            end
        end
    end
endmodule

// File: rtl/conv1d_dbuf_engine.sv
// rtl/conv1d_dbuf_engine.sv - valid-mode 1-D convolution with run-time filter and ping-pong x buffer
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   f_data/f_valid/f_ready     filter stream: f[0..M-1] then bias
//   x_data/x_valid/x_ready     input vectors, N words each
//   relu_en                    ReLU select, latched when a vector's compute starts
//   y_data/y_valid/y_ready     output stream, L words per vector
module conv1d_dbuf_engine
    import conv1d_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [T-1:0] f_data,
    input  logic         f_valid,
    output logic         f_ready,
    input  logic [T-1:0] x_data,
    input  logic         x_valid,
    output logic         x_ready,
    input  logic         relu_en,
    output logic [T-1:0] y_data,
    output logic         y_valid,
    input  logic         y_ready
);
    top_state_t  t_state, t_next;
    comp_state_t c_state, c_next;

    logic signed [T-1:0] f_mem [M];
    logic signed [T-1:0] bias;
    logic [F_AW-1:0]     f_cnt;
    logic                f_fire;

    logic signed [T-1:0] x_mem [2][N];
    logic [X_AW-1:0]     x_cnt;
    logic                wr_bank;
    logic                rd_bank;
    logic [1:0]          full;
    logic [1:0]          fill_mask;
    logic [1:0]          free_mask;
    logic                x_fire;

    logic [G_AW-1:0]     grp;
    logic [A_AW-1:0]     base;
    logic [A_AW-1:0]     remaining;
    logic [F_AW-1:0]     rk;
    logic [F_AW-1:0]     mac_k;
    logic [J_AW-1:0]     oj;
    logic [J_AW-1:0]     last_lane;
    logic                relu_q;
    logic                y_fire;
    logic                group_done;
    logic                more_groups;
    logic signed [T-1:0] f_rd;
    logic signed [T-1:0] lane_acc [P];
    logic signed [T-1:0] y_sel;

    // ---------------- top FSM: filter load, then run forever ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            t_state <= TOP_LOAD_F;
        end else begin
            t_state <= t_next;
        end
    end

    always_comb begin
        t_next  = t_state;
        f_ready = 1'b0;
        case (t_state)
            TOP_LOAD_F: begin
                f_ready = 1'b1;
                if (f_valid && f_cnt == F_AW'(M)) begin
                    t_next = TOP_RUN;
                end
            end
            default: ;
        endcase
    end

    assign f_fire = f_valid && f_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            f_cnt <= '0;
            bias  <= '0;
        end else if (f_fire) begin
            if (f_cnt == F_AW'(M)) begin
                bias <= f_data;
            end else begin
                f_mem[f_cnt] <= f_data;
            end
            f_cnt <= f_cnt + F_AW'(1);
        end
    end

    // ---------------- x writer ----------------
    assign x_ready   = (t_state == TOP_RUN) && !full[wr_bank];
    assign x_fire    = x_valid && x_ready;
    assign fill_mask = (x_fire && x_cnt == X_AW'(N - 1)) ? (2'b01 << wr_bank) : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt   <= '0;
            wr_bank <= 1'b0;
        end else if (x_fire) begin
            if (x_cnt == X_AW'(N - 1)) begin
                x_cnt   <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                x_cnt <= x_cnt + X_AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (x_fire) begin
            x_mem[wr_bank][x_cnt] <= x_data;
        end
    end

    // ---------------- compute sequencer ----------------
    assign base        = A_AW'(grp * P);
    assign remaining   = A_AW'(L) - base;
    assign last_lane   = (remaining >= A_AW'(P)) ? J_AW'(P - 1) : J_AW'(remaining - 1'b1);
    assign group_done  = (oj == last_lane);
    assign more_groups = (grp != G_AW'(NG - 1));
    assign y_valid     = (c_state == C_OUT);
    assign y_fire      = y_valid && y_ready;
    assign free_mask   = (y_fire && group_done && !more_groups) ? (2'b01 << rd_bank) : 2'b00;

    always_comb begin
        c_next = c_state;
        case (c_state)
            C_IDLE:  if (full[rd_bank]) c_next = C_CLR;
            C_CLR:   c_next = C_PIPE1;
            C_PIPE1: c_next = C_PIPE2;
            C_PIPE2: c_next = C_MAC;
            C_MAC:   if (mac_k == F_AW'(M - 1)) c_next = C_OUT;
            C_OUT:   if (y_fire && group_done) c_next = more_groups ? C_CLR : C_IDLE;
            default: c_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_state <= C_IDLE;
            rd_bank <= 1'b0;
            full    <= 2'b00;
            grp     <= '0;
            rk      <= '0;
            mac_k   <= '0;
            oj      <= '0;
            relu_q  <= 1'b0;
        end else begin
            c_state <= c_next;
            // fill and free always target different banks, so both take effect together
            full    <= (full & ~free_mask) | fill_mask;
            case (c_state)
                C_IDLE: begin
                    if (full[rd_bank]) begin
                        relu_q <= relu_en;
                        grp    <= '0;
                    end
                end
                C_CLR: begin
                    rk    <= '0;
                    mac_k <= '0;
                    oj    <= '0;
                end
                // read index runs two cycles ahead of the MAC index (read reg + product reg)
                C_PIPE1, C_PIPE2: rk <= rk + F_AW'(1);
                C_MAC: begin
                    rk    <= rk + F_AW'(1);
                    mac_k <= mac_k + F_AW'(1);
                end
                C_OUT: begin
                    if (y_fire) begin
                        if (group_done) begin
                            oj <= '0;
                            if (more_groups) begin
                                grp <= grp + G_AW'(1);
                            end else begin
                                rd_bank <= ~rd_bank;
                            end
                        end else begin
                            oj <= oj + J_AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // filter tap broadcast to every lane; out-of-range tail reads are harmless
    always_ff @(posedge clk) begin
        f_rd <= f_mem[(rk < F_AW'(M)) ? rk : '0];
    end

    for (genvar j = 0; j < P; j++) begin : g_lane
        logic [A_AW-1:0]     addr;
        logic signed [T-1:0] x_rd;

        assign addr = base + A_AW'(j) + A_AW'(rk);

        always_ff @(posedge clk) begin
            x_rd <= x_mem[rd_bank][(addr < A_AW'(N)) ? addr[X_AW-1:0] : '0];
        end

        conv1d_lane u_lane (
            .clk       (clk),
            .reset     (reset),
            .load_bias (c_state == C_CLR),
            .enable    (c_state == C_MAC),
            .x         (x_rd),
            .f         (f_rd),
            .bias      (bias),
            .acc       (lane_acc[j])
        );
    end

    // ---------------- output select ----------------
    always_comb begin
        y_sel = '0;
        for (int j = 0; j < P; j++) begin
            if (oj == J_AW'(j)) begin
                y_sel = lane_acc[j];
            end
        end
        if (relu_q && y_sel[T-1]) begin
            y_sel = '0;
        end
        y_data = y_valid ? y_sel : '0;
    end
endmodule
